// File: rtl/sr_latch_driver.sv
// sr_latch_driver: turns raw, bouncy set/clear request levels into clean,
// fixed-width drive pulses for a downstream SR latch.
//
// Each request goes through a 2-flop synchronizer and a debouncer. A debounced
// 0->1 edge becomes a one-cycle event. An FSM turns each event into
// PULSE_CYCLES of s (or r) with enable, followed by GAP_CYCLES of all-zero
// drive. An event that arrives while the FSM is busy is held in a one-deep
// pending flag, one per request type. Simultaneous set and clear events
// cancel each other and raise 'conflict' for one cycle.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   set_req   raw asynchronous set request (level)
//   rst_req   raw asynchronous clear request (level)
//   s, r      set / reset drive to the latch (registered)
//   enable    latch enable, high only while s or r is driven (registered)
//   busy      FSM not IDLE (registered)
//   conflict  one-cycle pulse when a set/clear pair was discarded (registered)

// Per-request lane: synchronizer, debounce counter and rising-edge detector.
module sr_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic rise_o
);
  localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES);

  logic       sync1_q, sync2_q;
  logic       lvl_q, lvl_d;
  logic       rise_q;
  logic [7:0] cnt_q, cnt_d;

  // The counter runs only while the synchronized sample disagrees with the
  // accepted level. It stops at CNT_MAX, where the level flips and the
  // counter clears, so it can never wrap.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = cnt_q;
    if (sync2_q == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      lvl_d = ~lvl_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      lvl_q   <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      rise_q  <= lvl_d & ~lvl_q;
    end
  end

  assign rise_o = rise_q;
endmodule

module sr_latch_driver #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned PULSE_CYCLES    = 2,
  parameter int unsigned GAP_CYCLES      = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_req,
  input  logic rst_req,
  output logic s,
  output logic r,
  output logic enable,
  output logic busy,
  output logic conflict
);
  typedef enum logic [1:0] {IDLE, SET_PULSE, CLR_PULSE, GAP} state_e;

  localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);

  // Lane 0 carries set, lane 1 carries clear.
  logic [1:0] raw, rise;
  logic       set_evt, clr_evt;

  assign raw     = {rst_req, set_req};
  assign set_evt = rise[0];
  assign clr_evt = rise[1];

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb [1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_i (raw),
    .rise_o(rise)
  );

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       pend_set_q, pend_set_d, pend_clr_q, pend_clr_d;
  logic       conflict_d;
  logic       dispatch, want_set, want_clr;
  logic       s_q, r_q, en_q, busy_q, conflict_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_set_d = pend_set_q;
    pend_clr_d = pend_clr_q;
    conflict_d = 1'b0;
    dispatch   = 1'b0;
    // An event arriving in the dispatch cycle itself is merged with the
    // pending flags so it is never lost.
    want_set   = pend_set_q | set_evt;
    want_clr   = pend_clr_q | clr_evt;

    unique case (state_q)
      IDLE: dispatch = 1'b1;
      SET_PULSE, CLR_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) dispatch = 1'b1;
        else                   cnt_d    = cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase

    if (dispatch) begin
      cnt_d      = '0;
      pend_set_d = 1'b0;
      pend_clr_d = 1'b0;
      if (want_set && want_clr) begin
        conflict_d = 1'b1;
        state_d    = IDLE;
      end else if (want_set) begin
        state_d = SET_PULSE;
      end else if (want_clr) begin
        state_d = CLR_PULSE;
      end else begin
        state_d = IDLE;
      end
    end else begin
      pend_set_d = want_set;
      pend_clr_d = want_clr;
    end
  end

  // Outputs are decoded from the next state, so they change on the same edge
  // as the state register and always agree with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pend_set_q <= 1'b0;
      pend_clr_q <= 1'b0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_set_q <= pend_set_d;
      pend_clr_q <= pend_clr_d;
      s_q        <= (state_d == SET_PULSE);
      r_q        <= (state_d == CLR_PULSE);
      en_q       <= (state_d == SET_PULSE) || (state_d == CLR_PULSE);
      busy_q     <= (state_d != IDLE);
      conflict_q <= conflict_d;
    end
  end

  assign s        = s_q;
  assign r        = r_q;
  assign enable   = en_q;
  assign busy     = busy_q;
  assign conflict = conflict_q;
endmodule

// File: tb/tb_sr_latch_driver.sv
module tb_sr_latch_driver;
  localparam int D = 4;
  localparam int P = 2;
  localparam int G = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic set_req = 1'b0;
  logic rst_req = 1'b0;
  logic s, r, enable, busy, conflict;

  sr_latch_driver #(.DEBOUNCE_CYCLES(D), .PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .set_req(set_req), .rst_req(rst_req),
    .s(s), .r(r), .enable(enable), .busy(busy), .conflict(conflict)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Output bundle order: {s, r, enable, busy, conflict}
  localparam logic [4:0] Z  = 5'b00000;
  localparam logic [4:0] SP = 5'b10110;
  localparam logic [4:0] RP = 5'b01110;
  localparam logic [4:0] GP = 5'b00010;
  localparam logic [4:0] CF = 5'b00001;

  typedef struct {
    logic       set_v;
    logic       rst_v;
    logic [4:0] exp;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [4:0] outs();
    return {s, r, enable, busy, conflict};
  endfunction

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got {s,r,en,busy,conf}=%b expected %b", name, act, exp);
    end
  endtask

  task automatic add(input int n, input logic a, input logic b, input logic [4:0] e);
    vec_t v;
    v.set_v = a; v.rst_v = b; v.exp = e;
    repeat (n) tbl.push_back(v);
  endtask

  // Reference model: a request level is accepted once the last D+1
  // synchronized samples (raw delayed by two edges) all oppose it. Accepted
  // events reach the FSM one edge later, and each dispatch appends its whole
  // output schedule to a queue that is drained one entry per edge.
  logic [D+2:0] m_hist[2];
  bit           m_lvl[2];
  bit           m_evt[2];
  bit           m_pend[2];
  int           m_q[$];
  logic [4:0]   m_out;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_hist[i] = '0; m_lvl[i] = 0; m_evt[i] = 0; m_pend[i] = 0;
    end
    m_q.delete();
    m_out = '0;
  endtask

  task automatic model_edge(input bit a, input bit b);
    bit ps, pc, conf_m, busy_m;
    bit rawv[2];
    int code;
    rawv[0] = a; rawv[1] = b;
    conf_m = 0;
    if (m_q.size() == 0) begin
      ps = m_pend[0] | m_evt[0];
      pc = m_pend[1] | m_evt[1];
      m_pend[0] = 0; m_pend[1] = 0;
      if (ps && pc) conf_m = 1;
      else if (ps || pc) begin
        repeat (P) m_q.push_back(ps ? 1 : 2);
        repeat (G) m_q.push_back(0);
      end
    end else begin
      m_pend[0] |= m_evt[0];
      m_pend[1] |= m_evt[1];
    end
    if (m_q.size() > 0) begin code = m_q.pop_front(); busy_m = 1; end
    else begin code = 0; busy_m = 0; end
    m_out = {code == 1, code == 2, code != 0, busy_m, conf_m};
    for (int i = 0; i < 2; i++) begin
      m_hist[i] = {m_hist[i][D+1:0], rawv[i]};
      m_evt[i] = 0;
      if (m_hist[i][D+2:2] == (m_lvl[i] ? '0 : '1)) begin
        m_lvl[i] = !m_lvl[i];
        m_evt[i] = m_lvl[i];
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; set_req = 1'b0; rst_req = 1'b0;
    @(posedge clk); #1;
    chk("reset_state", outs(), Z);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic cyc(input logic a, input logic b, input string name, input logic [4:0] e);
    set_req = a; rst_req = b;
    @(posedge clk); #1;
    chk(name, outs(), e);
  endtask

  initial begin
    int hold_s, hold_r;

    // Vector table: per-cycle inputs and expected outputs after that edge.
    add(7, 1, 0, Z); add(2, 1, 0, SP); add(1, 1, 0, GP); add(2, 1, 0, Z);  // set held 12
    add(20, 0, 0, Z);
    add(3, 1, 0, Z); add(12, 0, 0, Z);                                   // 3-cycle glitch
    add(7, 1, 1, Z); add(1, 1, 1, CF); add(4, 1, 1, Z); add(20, 0, 0, Z); // conflict
    add(7, 0, 1, Z); add(2, 0, 1, RP); add(1, 0, 1, GP); add(20, 0, 0, Z); // clear alone

    do_reset();
    for (int i = 0; i < tbl.size(); i++)
      cyc(tbl[i].set_v, tbl[i].rst_v, $sformatf("tbl[%0d]", i), tbl[i].exp);

    // Clear accepted mid set pulse: s s gap r r gap idle.
    do_reset();
    for (int e = 0; e < 14; e++) begin
      logic [4:0] ex;
      case (e)
        7, 8:   ex = SP;
        9, 12:  ex = GP;
        10, 11: ex = RP;
        default: ex = Z;
      endcase
      cyc(1'b1, e >= 1, $sformatf("queued_clr[%0d]", e), ex);
    end
    for (int e = 0; e < 20; e++) cyc(1'b0, 1'b0, "queued_clr_idle", Z);

    // Reset during the second set-pulse cycle with set held.
    do_reset();
    for (int e = 0; e < 9; e++)
      cyc(1'b1, 1'b0, $sformatf("pre_rst[%0d]", e), (e >= 7) ? SP : Z);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", outs(), Z);
    @(posedge clk); #1;
    chk("held_rst", outs(), Z);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e < 10; e++)
      cyc(1'b1, 1'b0, $sformatf("post_rst[%0d]", e), (e == 7 || e == 8) ? SP : (e == 9) ? GP : Z);
    for (int e = 0; e < 20; e++) cyc(1'b0, 1'b0, "post_rst_idle", Z);

    // Random request levels against the reference model plus invariants.
    do_reset();
    hold_s = 0; hold_r = 0;
    for (int c = 0; c < 10000; c++) begin
      if (hold_s == 0) begin set_req = 1'($urandom); hold_s = $urandom_range(1, 14); end
      if (hold_r == 0) begin rst_req = 1'($urandom); hold_r = $urandom_range(1, 14); end
      hold_s--; hold_r--;
      @(posedge clk);
      model_edge(set_req, rst_req);
      #1;
      chk($sformatf("rand[%0d]", c), outs(), m_out);
      tests++;
      if ((s & r) || ((s | r) & ~enable) || (enable & ~busy)) begin
        fails++;
        $display("FAIL invariant[%0d]: got s=%b r=%b en=%b busy=%b", c, s, r, enable, busy);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sr_latch_driver.md
SR_LATCH_DRIVER -- requirements
Module: sr_latch_driver

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized samples needed to accept a request level change; legal range 1..255.
REQ-002 Parameter PULSE_CYCLES, default 2: cycles that s or r plus enable are driven per accepted event; legal range 1..255.
REQ-003 Parameter GAP_CYCLES, default 1: all-zero cycles after each pulse; legal range 1..255.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 set_req  input  1  raw asynchronous set request (button/level).
REQ-007 rst_req  input  1  raw asynchronous clear request (button/level).
REQ-008 s  output  1  set drive to the downstream sr_latch.
REQ-009 r  output  1  reset drive to the downstream sr_latch.
REQ-010 enable  output  1  latch enable to the downstream sr_latch.
REQ-011 busy  output  1  high whenever the FSM is not IDLE.
REQ-012 conflict  output  1  one-cycle pulse when set and clear events must be discarded together.

Function
REQ-013 Each raw request SHALL pass through a two-flop synchronizer, reset value 0.
REQ-014 Each synchronized request SHALL have its own debounce counter and debounced level; the counter increments while the synchronized value differs from the debounced level, clears when they match, and the debounced level flips when the counter reaches DEBOUNCE_CYCLES.
REQ-015 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL clear the counter and produce no event.
REQ-016 Only a 0->1 transition of a debounced level SHALL produce a one-cycle event (set_evt or clr_evt); falling transitions produce nothing.
REQ-017 The FSM SHALL have states IDLE, SET_PULSE, CLR_PULSE and GAP, all registered.
REQ-018 IDLE: set_evt alone -> SET_PULSE; clr_evt alone -> CLR_PULSE; both in the same cycle -> conflict=1 for one cycle, remain IDLE.
REQ-019 SET_PULSE: s=1, r=0, enable=1 for exactly PULSE_CYCLES cycles, then GAP; CLR_PULSE identical with r=1, s=0.
REQ-020 GAP: s=r=enable=0 for exactly GAP_CYCLES cycles, then dispatch pending events as in REQ-018, else IDLE.
REQ-021 An event arriving while not IDLE SHALL set a one-deep pending flag for its type; repeated events of the same type while pending are merged.
REQ-022 At GAP exit with both pending flags set: conflict=1 for one cycle, both flags cleared, FSM to IDLE.
REQ-023 Dispatching a pending event SHALL clear its flag in the same cycle.
REQ-024 Latency: the first rising edge sampling a stable high request is edge 0; s (or r) and enable SHALL be 1 after edge DEBOUNCE_CYCLES+3 (edge 7 with defaults).
REQ-025 Invariants every cycle: s&r==0; (s|r) implies enable; enable implies state SET_PULSE or CLR_PULSE.
REQ-026 Counters SHALL be sized for 255 and never wrap.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 rst_n low SHALL immediately force s=r=enable=busy=conflict=0, state IDLE, synchronizers, debounced levels, counters and pending flags to 0, including mid-pulse.
REQ-029 After rst_n release, a request still held high SHALL be re-debounced from 0 and produce a fresh event per REQ-024.

Verification (defaults)
REQ-030 set_req high for 12 cycles after reset -> s=enable=1 after edges 7 and 8 only, r=0, busy=1 for 3 cycles, conflict=0.
REQ-031 set_req high for 3 cycles then low -> s, r, enable, busy remain 0 throughout.
REQ-032 set_req and rst_req rise in the same cycle and are held -> conflict=1 for exactly one cycle, s=r=enable=0, busy=0.
REQ-033 rst_req accepted during SET_PULSE -> s pulse (2 cycles), 1 all-zero cycle, r pulse (2 cycles), 1 gap cycle, then IDLE; busy high for 6 contiguous cycles.
REQ-034 rst_n low during the second SET_PULSE cycle with set_req held -> outputs 0 asynchronously; after release, s pulse returns 7 edges after the first post-reset sampling edge.
REQ-035 Random request stimulus for 10,000 cycles -> REQ-025 invariants never violated.
